// File: rtl/sha512_pkg.sv
// Shared SHA-512 constants and the padder state encoding.
package sha512_pkg;
  localparam int SHA512_WORD_W   = 64;
  localparam int SHA512_BLOCK_W  = 1024;
  localparam int SHA512_WORDS    = 16;
  localparam int SHA512_LEN_SLOT = 14;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} pad_state_t;
endpackage

// File: rtl/sha512_pad_word.sv
// Keeps the first nbytes bytes of a big-endian word, puts 0x80 at byte nbytes, zeros the rest.
module sha512_pad_word
  import sha512_pkg::*;
(
  input  logic [SHA512_WORD_W-1:0] word,
  input  logic [3:0]               nbytes,
  output logic [SHA512_WORD_W-1:0] padded
);
  always_comb begin
    padded = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes)       padded[63-8*k -: 8] = word[63-8*k -: 8];
      else if (4'(k) == nbytes) padded[63-8*k -: 8] = PAD_BYTE;
    end
  end
endmodule

// File: rtl/sha512_pad.sv
// SHA-512 message padder/blocker: 64-bit word stream in, 1024-bit padded blocks out.
// Define SHA512_PAD_ERR_EN to add the sticky pad_err output.
module sha512_pad
  import sha512_pkg::*;
#(
  parameter int LEN_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SHA512_WORD_W-1:0]  in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [3:0]                in_bytes,
  output logic                      in_ready,
  output logic [SHA512_BLOCK_W-1:0] blk,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic                      blk_first,
  output logic                      blk_last
`ifdef SHA512_PAD_ERR_EN
  ,
  output logic                      pad_err
`endif
);
  pad_state_t state, state_nxt;
  logic [SHA512_WORDS-1:0][SHA512_WORD_W-1:0] words;
  logic [3:0]       idx;
  logic [LEN_W-1:0] len, len_sum;
  logic             first_pending, last_r, extra, extra_marker;
  logic             acc, hs, pad_next, fits;
  logic [3:0]       b_eff;
  logic [6:0]       add_bits;
  logic [4:0]       pad_idx;
  logic [127:0]     len_sum_f, len_reg_f;
  logic [SHA512_WORD_W-1:0] word_pad;

  assign in_ready  = (state == FILL) && !rst;
  assign blk_valid = (state == EMIT);
  assign blk_first = blk_valid && first_pending;
  assign blk_last  = blk_valid && last_r;
  assign acc       = in_valid && in_ready;
  assign hs        = blk_valid && blk_ready;

  assign b_eff     = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign pad_next  = b_eff[3];
  assign add_bits  = in_last ? {b_eff, 3'b000} : 7'd64;
  assign len_sum   = len + LEN_W'(add_bits);
  assign len_sum_f = 128'(len_sum);
  assign len_reg_f = 128'(len);
  // 0x80 position decides whether the length still fits after it in this block
  assign pad_idx   = {1'b0, idx} + {4'd0, pad_next};
  assign fits      = pad_idx < 5'(SHA512_LEN_SLOT);

  sha512_pad_word u_word (.word(in_data), .nbytes(b_eff), .padded(word_pad));

  always_comb begin
    blk = '0;
    for (int i = 0; i < SHA512_WORDS; i++) blk[SHA512_BLOCK_W-1-64*i -: 64] = words[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (acc && (in_last || idx == 4'd15)) state_nxt = EMIT;
      EMIT:    if (hs) state_nxt = extra ? EXTRA : FILL;
      EXTRA:   state_nxt = EMIT;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words         <= '0;
      idx           <= '0;
      len           <= '0;
      first_pending <= 1'b1;
      last_r        <= 1'b0;
      extra         <= 1'b0;
      extra_marker  <= 1'b0;
    end else begin
      case (state)
        FILL: if (acc) begin
          len <= len_sum;
          if (!in_last) begin
            words[idx] <= in_data;
            idx        <= idx + 4'd1;
            last_r     <= 1'b0;
          end else begin
            idx <= '0;
            for (int j = 0; j < SHA512_WORDS; j++) begin
              if (4'(j) == idx)
                words[j] <= word_pad;
              else if (4'(j) > idx)
                words[j] <= (pad_next && 4'(j) == idx + 4'd1) ? {PAD_BYTE, 56'd0} : '0;
            end
            if (fits) begin
              words[SHA512_LEN_SLOT]   <= len_sum_f[127:64];
              words[SHA512_LEN_SLOT+1] <= len_sum_f[63:0];
              last_r                   <= 1'b1;
            end else begin
              last_r       <= 1'b0;
              extra        <= 1'b1;
              extra_marker <= pad_next && (idx == 4'd15);
            end
          end
        end
        EMIT: if (hs) begin
          first_pending <= 1'b0;
          if (!extra && last_r) begin
            len           <= '0;
            first_pending <= 1'b1;
          end
        end
        EXTRA: begin
          words                    <= '0;
          words[0]                 <= extra_marker ? {PAD_BYTE, 56'd0} : '0;
          words[SHA512_LEN_SLOT]   <= len_reg_f[127:64];
          words[SHA512_LEN_SLOT+1] <= len_reg_f[63:0];
          last_r                   <= 1'b1;
          extra                    <= 1'b0;
          extra_marker             <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SHA512_PAD_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pad_err <= 1'b0;
    else if (acc && ((in_last && in_bytes > 4'd8) || len_sum < len)) pad_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_sha512_pad.sv
// Randomized bench for sha512_pad against a byte-level FIPS 180-4 padding model.
module tb_sha512_pad;
  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   in_data;
  logic          in_valid, in_last;
  logic [3:0]    in_bytes;
  logic          in_ready;
  logic [1023:0] blk;
  logic          blk_valid, blk_ready, blk_first, blk_last;
`ifdef SHA512_PAD_ERR_EN
  logic          pad_err;
`endif

  always #5 clk = ~clk;

  sha512_pad dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready), .blk(blk), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_first(blk_first), .blk_last(blk_last)
`ifdef SHA512_PAD_ERR_EN
    , .pad_err(pad_err)
`endif
  );

  typedef struct {
    logic [1023:0] data;
    logic          first;
    logic          last;
  } blk_t;

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b1;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Padded byte stream: msg || 80 || 00.. || 128-bit big-endian bit length
  task automatic model(input byte unsigned m[$]);
    byte unsigned p[$];
    longint unsigned bits;
    blk_t b;
    int nblk;
    p = m;
    bits = 64'(m.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    nblk = p.size() / 128;
    for (int k = 0; k < nblk; k++) begin
      b.data = '0;
      for (int i = 0; i < 128; i++) b.data[1023-8*i -: 8] = p[128*k+i];
      b.first = (k == 0);
      b.last  = (k == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic rand_msg(input int n, output byte unsigned m[$]);
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
  endtask

  // Starts and ends at posedge+1; stop_after >= 0 aborts after that many words
  task automatic send(input byte unsigned m[$], input int stop_after);
    int n, nw, t, rem;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      if (stop_after >= 0 && w >= stop_after) break;
      if ($urandom % 4 == 0) begin
        in_valid = 1'b0;
        repeat (1 + $urandom % 2) @(posedge clk);
        #1;
      end
      for (int k = 0; k < 8; k++)
        in_data[63-8*k -: 8] = (8*w + k < n) ? m[8*w+k] : 8'($urandom);
      in_last  = (w == nw - 1);
      in_bytes = 4'($urandom);
      if (in_last) begin
        rem = n - 8 * w;
        in_bytes = 4'(rem);
        if (rem == 8 && $urandom % 3 == 0) in_bytes = 4'(9 + $urandom % 7);
      end
      in_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 200);
      chk("in_ready_wait", 1024'(in_ready), 1024'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 1024'(exp_q.size()), 1024'(0));
  endtask

  task automatic run(input byte unsigned m[$]);
    model(m);
    send(m, -1);
    drain();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) blk_ready = ($urandom % 3 != 0);
  end

  // Output monitor: compares each handshaken block and checks hold-while-stalled
  initial begin
    logic [1023:0] hold_blk;
    logic hold_f, hold_l;
    bit holding;
    blk_t e;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) holding = 1'b0;
      else if (blk_valid) begin
        if (holding) begin
          chk("hold_blk", blk, hold_blk);
          chk("hold_first", 1024'(blk_first), 1024'(hold_f));
          chk("hold_last", 1024'(blk_last), 1024'(hold_l));
        end
        if (blk_ready) begin
          holding = 1'b0;
          if (exp_q.size() == 0) chk("unexpected_blk", 1024'(1), 1024'(0));
          else begin
            e = exp_q.pop_front();
            chk("blk", blk, e.data);
            chk("blk_first", 1024'(blk_first), 1024'(e.first));
            chk("blk_last", 1024'(blk_last), 1024'(e.last));
          end
        end else begin
          holding  = 1'b1;
          hold_blk = blk;
          hold_f   = blk_first;
          hold_l   = blk_last;
        end
      end else begin
        if (holding) chk("valid_drop", 1024'(0), 1024'(1));
        holding = 1'b0;
      end
    end
  end

  initial begin
    byte unsigned m[$];
    byte unsigned abc[$];
    logic [1023:0] cap;
    int t;
    abc = '{8'h61, 8'h62, 8'h63};
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
    blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 1024'(in_ready), 1024'(0));
    chk("rst_blk_valid", 1024'(blk_valid), 1024'(0));
    chk("rst_blk", blk, 1024'(0));
    chk("rst_first_last", 1024'({blk_first, blk_last}), 1024'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(abc);
    rand_msg(0, m);   run(m);
    rand_msg(111, m); run(m);
    rand_msg(112, m); run(m);
    rand_msg(128, m); run(m);
    rand_msg(120, m); run(m);
    rand_msg(64, m);  run(m);

    // backpressure: block must hold and input must stall
    rand_ready = 1'b0;
    blk_ready  = 1'b0;
    model(abc);
    send(abc, -1);
    t = 0;
    while (!blk_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid", 1024'(blk_valid), 1024'(1));
    cap = blk;
    repeat (5) begin
      @(negedge clk);
      chk("bp_blk_stable", blk, cap);
      chk("bp_in_ready", 1024'(in_ready), 1024'(0));
      chk("bp_blk_valid", 1024'(blk_valid), 1024'(1));
    end
    rand_ready = 1'b1;
    @(posedge clk);
    drain();

    // reset part way through a message
    rand_msg(100, m);
    send(m, 7);
    rst = 1'b1;
    #1;
    chk("mid_rst_blk", blk, 1024'(0));
    chk("mid_rst_valid", 1024'(blk_valid), 1024'(0));
    chk("mid_rst_in_ready", 1024'(in_ready), 1024'(0));
    chk("mid_rst_first_last", 1024'({blk_first, blk_last}), 1024'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 1024'(blk_valid), 1024'(0));
    @(posedge clk);
    #1;
    run(abc);

    for (int r = 0; r < 20; r++) begin
      rand_msg($urandom_range(0, 300), m);
      run(m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
